tune_word_gen: RTL

Upstream stage of the DDS phase accumulator. Debounces the active-low set key and captures the 10-bit switch value on each press. It then computes the 28-bit tuning word dec_val * BASE_TUNE with an iterative shift-add multiplier. The tuning word is held stable for the phase accumulator, which adds it every clock. This replaces the free-running combinational multiply with a registered, handshaked result.

---
 rtl/tune_word_gen_if.sv | 23 ++
 rtl/tune_word_gen.sv | 109 ++++++++++
 2 files changed

// File: rtl/tune_word_gen_if.sv
// Tuning-word output bundle from tune_word_gen to the DDS phase accumulator.
interface tune_word_gen_if #(
    parameter int TUNE_W = 28
);
    logic [TUNE_W-1:0] tuner;
    logic [15:0]       dec_val;
    logic              tune_valid;
    logic              busy;

    modport master (
        output tuner,
        output dec_val,
        output tune_valid,
        output busy
    );

    modport slave (
        input tuner,
        input dec_val,
        input tune_valid,
        input busy
    );
endinterface

// File: rtl/tune_word_gen.sv
// Debounced key capture of the switch value and shift-add tuning-word multiply.
module tune_word_gen #(
    parameter int SW_W            = 10,
    parameter int TUNE_W          = 28,
    parameter int BASE_TUNE       = 26844,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [SW_W-1:0]   sw,
    input  logic              set,
    tune_word_gen_if.master   tw
);
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int CNT_W = $clog2(SW_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    state_t              state;
    logic                s1;
    logic                s2;
    logic                level;
    logic                press;
    logic [DB_W-1:0]     db_cnt;
    logic [SW_W-1:0]     mplier;
    logic [TUNE_W-1:0]   mcand;
    logic [TUNE_W-1:0]   acc;
    logic [CNT_W-1:0]    cnt;

    // Level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (clr) begin
            s1     <= 1'b1;
            s2     <= 1'b1;
            level  <= 1'b1;
            db_cnt <= '0;
            press  <= 1'b0;
        end else begin
            s1    <= set;
            s2    <= s1;
            press <= 1'b0;
            if (s2 != level) begin
                if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    level  <= s2;
                    db_cnt <= '0;
                    press  <= ~s2;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state         <= IDLE;
            mplier        <= '0;
            mcand         <= '0;
            acc           <= '0;
            cnt           <= '0;
            tw.tuner      <= '0;
            tw.dec_val    <= '0;
            tw.tune_valid <= 1'b0;
            tw.busy       <= 1'b0;
        end else begin
            tw.tune_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (press) begin
                        tw.dec_val <= 16'(sw);
                        mplier     <= sw;
                        mcand      <= TUNE_W'(BASE_TUNE);
                        acc        <= '0;
                        cnt        <= '0;
                        tw.busy    <= 1'b1;
                        state      <= MUL;
                    end
                end
                MUL: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_W'(SW_W - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    tw.tuner      <= acc;
                    tw.tune_valid <= 1'b1;
                    tw.busy       <= 1'b0;
                    state         <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    tw.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule
